// File: rtl/matmul_pkg.sv
// Shared types and width helper for the 4x4 complex matrix multiplier and its stream controller.
package matmul_pkg;

  localparam int unsigned MAT_N    = 4;
  localparam int unsigned MAT_ELEM = MAT_N * MAT_N;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } ctrl_state_t;

  typedef logic [3:0] idx_t;

  // Result component width: two W-bit products plus growth for the 4-term complex sum.
  function automatic int unsigned cw(input int unsigned w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/matmul4x4_stream_ctrl.sv
// Stream controller: loads A then B serially, waits for the multiplier, streams C out row-major.
module matmul4x4_stream_ctrl
  import matmul_pkg::*;
#(
  parameter  int unsigned W       = 16,
  parameter  int unsigned MUL_LAT = 1,
  localparam int unsigned CW      = cw(W)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                in_re,
  input  logic [W-1:0]                in_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CW-1:0]               out_re,
  output logic [CW-1:0]               out_im,
  output logic                        out_last,
  output logic                        busy,
  output logic [0:3][0:3][W-1:0]      a_re,
  output logic [0:3][0:3][W-1:0]      a_im,
  output logic [0:3][0:3][W-1:0]      b_re,
  output logic [0:3][0:3][W-1:0]      b_im,
  input  logic [0:3][0:3][CW-1:0]     c_re,
  input  logic [0:3][0:3][CW-1:0]     c_im
);

  localparam int unsigned WAIT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  ctrl_state_t state_q, state_d;
  idx_t        idx_q, idx_d, idx_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [0:3][0:3][W-1:0]  a_re_q, a_re_d, a_im_q, a_im_d;
  logic [0:3][0:3][W-1:0]  b_re_q, b_re_d, b_im_q, b_im_d;
  logic [0:3][0:3][CW-1:0] res_re_q, res_re_d, res_im_q, res_im_d;

  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;

  assign idx_inc = idx_q + 4'd1;

  // Next-state, operand/result bank and registered output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    res_re_d    = res_re_q;
    res_im_d    = res_im_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    if (flush) begin
      // Abort wins over any handshake; operand and result banks are left as they are.
      state_d     = ST_LOAD_A;
      idx_d       = '0;
      wait_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD_A, ST_LOAD_B: begin
          if (in_valid) begin
            if (state_q == ST_LOAD_A) begin
              a_re_d[idx_q[3:2]][idx_q[1:0]] = in_re;
              a_im_d[idx_q[3:2]][idx_q[1:0]] = in_im;
            end else begin
              b_re_d[idx_q[3:2]][idx_q[1:0]] = in_re;
              b_im_d[idx_q[3:2]][idx_q[1:0]] = in_im;
            end
            idx_d = idx_inc;
            if (idx_q == 4'd15) begin
              state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_COMPUTE;
              wait_d  = '0;
            end
          end
        end
        ST_COMPUTE: begin
          // Capture on the MUL_LAT-th edge after the last operand write.
          if (wait_q == WAIT_W'(MUL_LAT - 1)) begin
            res_re_d    = c_re;
            res_im_d    = c_im;
            idx_d       = '0;
            wait_d      = '0;
            state_d     = ST_DRAIN;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_re_d    = c_re[0][0];
            out_im_d    = c_im[0][0];
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (idx_q == 4'd15) begin
              state_d     = ST_LOAD_A;
              idx_d       = '0;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              idx_d      = idx_inc;
              out_re_d   = res_re_q[idx_inc[3:2]][idx_inc[1:0]];
              out_im_d   = res_im_q[idx_inc[3:2]][idx_inc[1:0]];
              out_last_d = (idx_inc == 4'd15);
            end
          end
        end
        default: begin
          state_d = ST_LOAD_A;
        end
      endcase
    end

    in_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    busy_d     = (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
  end

  // State, banks and outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD_A;
      idx_q       <= '0;
      wait_q      <= '0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign a_re      = a_re_q;
  assign a_im      = a_im_q;
  assign b_re      = b_re_q;
  assign b_im      = b_im_q;

endmodule

// File: tb/tb_matmul4x4_stream_ctrl.sv
// Directed bench for the stream controller with a combinational and a 3-cycle multiplier model.
module tb_matmul4x4_stream_ctrl;
  import matmul_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = cw(W);

  typedef int mat_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic dsel = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;

  logic in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
  logic [CW-1:0] out_re1, out_im1, out_re3, out_im3;
  logic [0:3][0:3][W-1:0]  a1_re, a1_im, b1_re, b1_im, a3_re, a3_im, b3_re, b3_im;
  logic [0:3][0:3][CW-1:0] c1_re, c1_im, m3_re, m3_im, p3_re, p3_im, c3_re, c3_im;

  logic sel_valid, sel_last, sel_busy, sel_in_ready;
  logic [CW-1:0] sel_re, sel_im;

  mat_t ar, ai, br, bi, er, ei;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign in_valid1  = in_valid & ~dsel;
  assign in_valid3  = in_valid & dsel;
  assign out_ready1 = dsel | out_ready;
  assign out_ready3 = ~dsel | out_ready;
  assign sel_valid    = dsel ? out_valid3 : out_valid1;
  assign sel_last     = dsel ? out_last3 : out_last1;
  assign sel_busy     = dsel ? busy3 : busy1;
  assign sel_in_ready = dsel ? in_ready3 : in_ready1;
  assign sel_re       = dsel ? out_re3 : out_re1;
  assign sel_im       = dsel ? out_im3 : out_im1;

  matmul4x4_stream_ctrl #(.W(W), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_re(out_re1), .out_im(out_im1),
    .out_last(out_last1), .busy(busy1),
    .a_re(a1_re), .a_im(a1_im), .b_re(b1_re), .b_im(b1_im), .c_re(c1_re), .c_im(c1_im)
  );

  matmul4x4_stream_ctrl #(.W(W), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_re(out_re3), .out_im(out_im3),
    .out_last(out_last3), .busy(busy3),
    .a_re(a3_re), .a_im(a3_im), .b_re(b3_re), .b_im(b3_im), .c_re(c3_re), .c_im(c3_im)
  );

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference complex multiply-accumulate for one C element.
  function automatic logic [CW-1:0] cmac(input logic [0:3][0:3][W-1:0] xr, xi, yr, yi,
                                         input int i, input int j, input bit want_im);
    longint acc = 0;
    for (int k = 0; k < 4; k++) begin
      if (want_im) acc += sx(xr[i][k]) * sx(yi[k][j]) + sx(xi[i][k]) * sx(yr[k][j]);
      else         acc += sx(xr[i][k]) * sx(yr[k][j]) - sx(xi[i][k]) * sx(yi[k][j]);
    end
    return CW'(acc);
  endfunction

  // Combinational multiplier for the MUL_LAT=1 instance.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c1_re[i][j] = cmac(a1_re, a1_im, b1_re, b1_im, i, j, 1'b0);
        c1_im[i][j] = cmac(a1_re, a1_im, b1_re, b1_im, i, j, 1'b1);
        m3_re[i][j] = cmac(a3_re, a3_im, b3_re, b3_im, i, j, 1'b0);
        m3_im[i][j] = cmac(a3_re, a3_im, b3_re, b3_im, i, j, 1'b1);
      end
    end
  end

  // Two register stages: results settle two edges after operands, captured on the third.
  always_ff @(posedge clk) begin
    p3_re <= m3_re;
    p3_im <= m3_im;
    c3_re <= p3_re;
    c3_im <= p3_im;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Stream all of A then nb elements of B, one per cycle; returns at the negedge after the last handshake.
  task automatic stream(input string tag, input int nb);
    check({tag, "_in_ready"}, int'(sel_in_ready), 1);
    for (int e = 0; e < 16 + nb; e++) begin
      in_valid = 1'b1;
      if (e < 16) begin
        in_re = W'(ar[e]);
        in_im = W'(ai[e]);
      end else begin
        in_re = W'(br[e - 16]);
        in_im = W'(bi[e - 16]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Drain C against er/ei, stalling stall_len cycles at element 7; stop early at abort_at.
  task automatic drain(input string tag, input int stall_len, input int abort_at);
    int n = 0;
    int vcyc = 0;
    int guard = 0;
    int stalls = 0;
    while (n < 16 && n != abort_at && guard < 64) begin
      guard++;
      if (sel_valid) begin
        vcyc++;
        check({tag, "_re"}, int'($signed(sel_re)), er[n]);
        check({tag, "_im"}, int'($signed(sel_im)), ei[n]);
        check({tag, "_last"}, int'(sel_last), (n == 15) ? 1 : 0);
        if (n == 7 && stalls < stall_len) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
          n++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (abort_at >= 16) begin
      check({tag, "_count"}, n, 16);
      check({tag, "_cycles"}, vcyc, 16 + stall_len);
      check({tag, "_valid_after"}, int'(sel_valid), 0);
      check({tag, "_ready_after"}, int'(sel_in_ready), 1);
    end
  endtask

  // Full product: stream, measure first out_valid in cycles after the last handshake, drain.
  task automatic run(input string tag, input int exp_lat, input int stall_len, input int abort_at);
    int lat = 1;
    stream(tag, 16);
    while (!sel_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy"}, int'(sel_busy), 1);
    drain(tag, stall_len, abort_at);
  endtask

  task automatic set_diag(input int dre, input int dim);
    for (int e = 0; e < 16; e++) begin
      ar[e] = (e / 4 == e % 4) ? dre : 0;
      ai[e] = (e / 4 == e % 4) ? dim : 0;
    end
  endtask

  task automatic set_bpat();
    for (int e = 0; e < 16; e++) begin
      br[e] = e;
      bi[e] = -e;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_out_last", int'(out_last1), 0);
    check("rst_out_re", int'($signed(out_re1)), 0);
    check("rst_in_ready", int'(in_ready1), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity times B.
    set_diag(1, 0);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = e;
      ei[e] = -e;
    end
    run("ident", 2, 0, 16);

    // All-ones complex: each element is 4 * (1+j)^2 = 8j.
    for (int e = 0; e < 16; e++) begin
      ar[e] = 1; ai[e] = 1; br[e] = 1; bi[e] = 1;
      er[e] = 0; ei[e] = 8;
    end
    run("ones", 2, 0, 16);

    // Output backpressure at C[1][3] = 7 - 7j.
    set_diag(1, 0);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = e;
      ei[e] = -e;
    end
    run("bp", 2, 5, 16);

    // Flush after 5 B elements, with an element offered in the flush cycle.
    for (int e = 0; e < 16; e++) begin
      ar[e] = 1; ai[e] = 1; br[e] = 99; bi[e] = 99;
    end
    stream("flush_pre", 5);
    in_valid = 1'b1;
    in_re = W'(77);
    in_im = W'(77);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", int'(in_ready1), 1);
    check("flush_busy", int'(busy1), 0);
    check("flush_out_valid", int'(out_valid1), 0);
    set_diag(2, 0);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = 2 * e;
      ei[e] = -2 * e;
    end
    run("flush", 2, 0, 16);

    // Asynchronous reset in the middle of DRAIN.
    set_diag(1, 0);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = e;
      ei[e] = -e;
    end
    run("pre_rst", 2, 0, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid1), 0);
    check("arst_busy", int'(busy1), 0);
    check("arst_out_last", int'(out_last1), 0);
    check("arst_out_re", int'($signed(out_re1)), 0);
    check("arst_in_ready", int'(in_ready1), 1);
    check("arst_a00", int'($signed(a1_re[0][0])), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // j*I times B: j*(x - jx) = x + jx.
    set_diag(0, 1);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = e;
      ei[e] = e;
    end
    run("post_rst", 2, 0, 16);

    // Three-cycle multiplier instance.
    dsel = 1'b1;
    set_diag(1, 0);
    set_bpat();
    for (int e = 0; e < 16; e++) begin
      er[e] = e;
      ei[e] = -e;
    end
    run("lat3", 4, 0, 16);
    dsel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
